// File: rtl/seg_scan_pkg.sv
// Shared constants for the seven-segment scan controller: blank pattern and
// the active-low hex glyph table {g,f,e,d,c,b,a}.
package seg_scan_pkg;

   localparam logic [7:0] SEG_OFF = 8'hFF;

   // Index 15 (F) is the leftmost entry; 'b' and 'd' are lower-case glyphs.
   localparam logic [15:0][6:0] HEX_SEG = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   function automatic logic [6:0] hex2seg(input logic [3:0] nibble);
      return HEX_SEG[nibble];
   endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low segment pattern (SEG[6:0]).
module seg_hex_decode
   import seg_scan_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = hex2seg(nibble);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode seven-segment scanner with frame-synchronous shadow
// registers and per-slot PWM. Define SEG_LZB_EN for leading-zero blanking.
module seg_scan_ctrl
   import seg_scan_pkg::*;
#(
   parameter int DIGITS        = 8,
   parameter int SCAN_DIV_LOG2 = 16,
   parameter int BRIGHT_W      = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   data_in,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic [DIGITS-1:0]     blank_in,
   input  logic                  load,
   input  logic [BRIGHT_W-1:0]   brightness,
   output logic [7:0]            SEG,
   output logic [DIGITS-1:0]     AN,
   output logic                  frame_tick
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [SCAN_DIV_LOG2-1:0] presc_q, presc_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic [4*DIGITS-1:0]      pend_data_q, pend_data_d, act_data_q, act_data_d;
   logic [DIGITS-1:0]        pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
   logic [DIGITS-1:0]        pend_blank_q, pend_blank_d, act_blank_q, act_blank_d;
   logic                     pend_vld_q, pend_vld_d;
   logic [7:0]               seg_q, seg_d;
   logic [DIGITS-1:0]        an_q, an_d;
   logic                     frame_tick_q, frame_tick_d;

   logic                     slot_end, fb, pwm_on, lit;
   logic [DIGITS-1:0]        lzb;
   logic [3:0]               cur_nib;
   logic                     cur_dp, cur_blank, cur_lzb;
   logic [6:0]               cur_seg7;

   assign slot_end = &presc_q;
   assign fb       = slot_end & (idx_q == IDX_W'(DIGITS - 1));

   always_comb begin
      presc_d = presc_q + 1'b1;
      idx_d   = idx_q;
      if (slot_end)
         idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
   end

   // Pending holds the last load of the frame; active only moves on the
   // frame boundary so a frame is never drawn from mixed data.
   always_comb begin
      pend_data_d  = pend_data_q;
      pend_dp_d    = pend_dp_q;
      pend_blank_d = pend_blank_q;
      pend_vld_d   = pend_vld_q;
      act_data_d   = act_data_q;
      act_dp_d     = act_dp_q;
      act_blank_d  = act_blank_q;
      if (load) begin
         pend_data_d  = data_in;
         pend_dp_d    = dp_in;
         pend_blank_d = blank_in;
         pend_vld_d   = 1'b1;
      end
      if (fb) begin
         pend_vld_d = 1'b0;
         if (load) begin
            act_data_d  = data_in;
            act_dp_d    = dp_in;
            act_blank_d = blank_in;
         end else if (pend_vld_q) begin
            act_data_d  = pend_data_q;
            act_dp_d    = pend_dp_q;
            act_blank_d = pend_blank_q;
         end
      end
   end

`ifdef SEG_LZB_EN
   logic zero_run;

   always_comb begin
      lzb      = '0;
      zero_run = 1'b1;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         zero_run = zero_run & (act_data_q[4*k +: 4] == 4'h0);
         if (k != 0)
            lzb[k] = zero_run & ~act_dp_q[k];
      end
   end
`else
   assign lzb = '0;
`endif

   always_comb begin
      cur_nib   = 4'h0;
      cur_dp    = 1'b0;
      cur_blank = 1'b1;
      cur_lzb   = 1'b0;
      for (int k = 0; k < DIGITS; k++) begin
         if (idx_q == IDX_W'(k)) begin
            cur_nib   = act_data_q[4*k +: 4];
            cur_dp    = act_dp_q[k];
            cur_blank = act_blank_q[k];
            cur_lzb   = lzb[k];
         end
      end
   end

   seg_hex_decode u_dec (
      .nibble (cur_nib),
      .seg    (cur_seg7)
   );

   // Brightness is sampled live so dimming responds within a slot.
   assign pwm_on = (&brightness) |
                   (presc_q[SCAN_DIV_LOG2-1 -: BRIGHT_W] < brightness);
   assign lit    = pwm_on & ~cur_blank & ~cur_lzb;

   always_comb begin
      an_d         = lit ? ~(DIGITS'(1) << idx_q) : '1;
      seg_d        = lit ? {~cur_dp, cur_seg7} : SEG_OFF;
      frame_tick_d = fb;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q      <= '0;
         idx_q        <= '0;
         pend_data_q  <= '0;
         pend_dp_q    <= '0;
         pend_blank_q <= '0;
         pend_vld_q   <= 1'b0;
         act_data_q   <= '0;
         act_dp_q     <= '0;
         act_blank_q  <= '0;
         seg_q        <= SEG_OFF;
         an_q         <= '1;
         frame_tick_q <= 1'b0;
      end else begin
         presc_q      <= presc_d;
         idx_q        <= idx_d;
         pend_data_q  <= pend_data_d;
         pend_dp_q    <= pend_dp_d;
         pend_blank_q <= pend_blank_d;
         pend_vld_q   <= pend_vld_d;
         act_data_q   <= act_data_d;
         act_dp_q     <= act_dp_d;
         act_blank_q  <= act_blank_d;
         seg_q        <= seg_d;
         an_q         <= an_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign SEG        = seg_q;
   assign AN         = an_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (8 digits, 16-cycle slots, 3-bit brightness).
module tb_seg_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] data_in = '0;
   logic [7:0]  dp_in = '0;
   logic [7:0]  blank_in = '0;
   logic        load = 1'b0;
   logic [2:0]  brightness = 3'd7;
   logic [7:0]  SEG;
   logic [7:0]  AN;
   logic        frame_tick;

   int vecs = 0;
   int miss = 0;

   logic [7:0] an_obs  [128];
   logic [7:0] seg_obs [128];
   logic       ft_obs  [128];

   always #5 clk = ~clk;

   seg_scan_ctrl #(.DIGITS(8), .SCAN_DIV_LOG2(4), .BRIGHT_W(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in),
      .dp_in      (dp_in),
      .blank_in   (blank_in),
      .load       (load),
      .brightness (brightness),
      .SEG        (SEG),
      .AN         (AN),
      .frame_tick (frame_tick)
   );

   // Expected outputs for frame cycle i (digit i/16, prescaler i%16).
   function automatic logic [7:0] f_an(input int i, input logic [2:0] br, input logic [7:0] mask);
      logic [7:0] one;
      int j, p;
      one = 8'h01;
      j = i / 16;
      p = i % 16;
      if (((br == 3'd7) || ((p / 2) < int'(br))) && mask[j]) return ~(one << j);
      return 8'hFF;
   endfunction

   function automatic logic [7:0] f_seg(input int i, input logic [2:0] br, input logic [7:0] mask,
                                        input logic [7:0][7:0] s);
      int j, p;
      j = i / 16;
      p = i % 16;
      if (((br == 3'd7) || ((p / 2) < int'(br))) && mask[j]) return s[j];
      return 8'hFF;
   endfunction

   // Records one frame of outputs, starting just after a frame_tick sample,
   // and issues up to two load strobes at the given frame cycles.
   task automatic capture_frame(input int la, input logic [31:0] da, input int lb, input logic [31:0] db);
      for (int i = 0; i < 128; i++) begin
         @(negedge clk);
         an_obs[i]  = AN;
         seg_obs[i] = SEG;
         ft_obs[i]  = frame_tick;
         load       = (i == la) || (i == lb);
         if (i == la) data_in = da;
         if (i == lb) data_in = db;
      end
      load = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         vecs++;
         if (AN !== 8'hFF || SEG !== 8'hFF || frame_tick !== 1'b0) begin
            miss++;
            $display("FAIL reset c=%0d AN=%h SEG=%h ft=%b, want FF FF 0", c, AN, SEG, frame_tick);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_scan;
      logic [7:0][7:0] s;
      s = {8{8'hC0}};
      capture_frame(-1, 0, -1, 0);
      for (int i = 0; i < 128; i++) begin
         vecs++;
         if (an_obs[i] !== f_an(i, 3'd7, 8'hFF) || seg_obs[i] !== f_seg(i, 3'd7, 8'hFF, s) ||
             ft_obs[i] !== (i == 127)) begin
            miss++;
            $display("FAIL scan i=%0d AN=%h SEG=%h ft=%b, want AN=%h SEG=%h", i, an_obs[i], seg_obs[i],
                     ft_obs[i], f_an(i, 3'd7, 8'hFF), f_seg(i, 3'd7, 8'hFF, s));
         end
      end
   endtask

   task automatic test_shadow;
      logic [1:0][7:0][7:0] s;
      s[0] = {8{8'hC0}};
      s[1] = {8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h0E};
      dp_in = 8'h01;
      blank_in = 8'h00;
      for (int f = 0; f < 2; f++) begin
         capture_frame(f == 0 ? 40 : -1, 32'h89ABCDEF, -1, 0);
         for (int i = 0; i < 128; i++) begin
            vecs++;
            if (an_obs[i] !== f_an(i, 3'd7, 8'hFF) || seg_obs[i] !== f_seg(i, 3'd7, 8'hFF, s[f]) ||
                ft_obs[i] !== (i == 127)) begin
               miss++;
               $display("FAIL shadow f=%0d i=%0d AN=%h SEG=%h ft=%b, want AN=%h SEG=%h", f, i, an_obs[i],
                        seg_obs[i], ft_obs[i], f_an(i, 3'd7, 8'hFF), f_seg(i, 3'd7, 8'hFF, s[f]));
            end
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [2:0][7:0][7:0] s;
      int la [3], lb [3];
      logic [31:0] da [3], db [3];
      s[0] = {8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h0E};
      s[1] = {8{8'hA4}};
      s[2] = {8{8'hB0}};
      la = '{20, 126, -1};  da = '{32'h11111111, 32'h33333333, 0};
      lb = '{60, -1, -1};   db = '{32'h22222222, 0, 0};
      dp_in = 8'h00;
      for (int f = 0; f < 3; f++) begin
         capture_frame(la[f], da[f], lb[f], db[f]);
         for (int i = 0; i < 128; i++) begin
            vecs++;
            if (an_obs[i] !== f_an(i, 3'd7, 8'hFF) || seg_obs[i] !== f_seg(i, 3'd7, 8'hFF, s[f]) ||
                ft_obs[i] !== (i == 127)) begin
               miss++;
               $display("FAIL b2b f=%0d i=%0d AN=%h SEG=%h ft=%b, want AN=%h SEG=%h", f, i, an_obs[i],
                        seg_obs[i], ft_obs[i], f_an(i, 3'd7, 8'hFF), f_seg(i, 3'd7, 8'hFF, s[f]));
            end
         end
      end
   endtask

   task automatic test_pwm;
      logic [7:0][7:0] s;
      logic [2:0] br [2];
      int want_cnt [2];
      int cnt;
      s = {8{8'hB0}};
      br = '{3'd0, 3'd2};
      want_cnt = '{0, 32};
      for (int f = 0; f < 2; f++) begin
         brightness = br[f];
         capture_frame(-1, 0, -1, 0);
         cnt = 0;
         for (int i = 0; i < 128; i++) begin
            if (an_obs[i] !== 8'hFF) cnt++;
            vecs++;
            if (an_obs[i] !== f_an(i, br[f], 8'hFF) || seg_obs[i] !== f_seg(i, br[f], 8'hFF, s)) begin
               miss++;
               $display("FAIL pwm br=%0d i=%0d AN=%h SEG=%h, want AN=%h SEG=%h", br[f], i, an_obs[i],
                        seg_obs[i], f_an(i, br[f], 8'hFF), f_seg(i, br[f], 8'hFF, s));
            end
         end
         vecs++;
         if (cnt !== want_cnt[f]) begin
            miss++;
            $display("FAIL pwm_count br=%0d lit=%0d, want %0d", br[f], cnt, want_cnt[f]);
         end
      end
      brightness = 3'd7;
   endtask

   task automatic test_blank;
      logic [1:0][7:0][7:0] s;
      logic [1:0][7:0] m;
      s[0] = {8{8'hB0}};
      s[1] = {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hB0, 8'hC0, 8'h92};
      m[0] = 8'hFF;
`ifdef SEG_LZB_EN
      m[1] = 8'h07;
`else
      m[1] = 8'h0F;
`endif
      for (int f = 0; f < 2; f++) begin
         blank_in = 8'hF0;
         capture_frame(f == 0 ? 10 : -1, 32'h00000305, -1, 0);
         for (int i = 0; i < 128; i++) begin
            vecs++;
            if (an_obs[i] !== f_an(i, 3'd7, m[f]) || seg_obs[i] !== f_seg(i, 3'd7, m[f], s[f]) ||
                ft_obs[i] !== (i == 127)) begin
               miss++;
               $display("FAIL blank f=%0d i=%0d AN=%h SEG=%h ft=%b, want AN=%h SEG=%h", f, i, an_obs[i],
                        seg_obs[i], ft_obs[i], f_an(i, 3'd7, m[f]), f_seg(i, 3'd7, m[f], s[f]));
            end
         end
      end
   endtask

   // Frame 0 still shows the blanked 305 image while leading-zero cases load.
   task automatic test_lzb;
      logic [3:0][7:0][7:0] s;
      logic [3:0][7:0] m;
      logic [7:0] ld_dp [4];
      logic [31:0] ld_data [4];
      s[0] = {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hB0, 8'hC0, 8'h92};
      s[1] = s[0];
      s[2] = {8{8'hC0}};
      s[3] = {8'hC0, 8'hC0, 8'hC0, 8'h40, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
`ifdef SEG_LZB_EN
      m = {8'h11, 8'h01, 8'h07, 8'h07};
`else
      m = {8'hFF, 8'hFF, 8'hFF, 8'h0F};
`endif
      ld_data = '{32'h00000305, 32'h00000000, 32'h00000000, 0};
      ld_dp   = '{8'h00, 8'h00, 8'h10, 8'h00};
      for (int f = 0; f < 4; f++) begin
         dp_in = ld_dp[f];
         blank_in = 8'h00;
         capture_frame(f < 3 ? 10 : -1, ld_data[f], -1, 0);
         for (int i = 0; i < 128; i++) begin
            vecs++;
            if (an_obs[i] !== f_an(i, 3'd7, m[f]) || seg_obs[i] !== f_seg(i, 3'd7, m[f], s[f]) ||
                ft_obs[i] !== (i == 127)) begin
               miss++;
               $display("FAIL lzb f=%0d i=%0d AN=%h SEG=%h ft=%b, want AN=%h SEG=%h", f, i, an_obs[i],
                        seg_obs[i], ft_obs[i], f_an(i, 3'd7, m[f]), f_seg(i, 3'd7, m[f], s[f]));
            end
         end
      end
   endtask

   task automatic test_async_reset;
      logic [7:0][7:0] s;
      s = {8{8'hC0}};
      repeat (37) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      vecs++;
      if (AN !== 8'hFF || SEG !== 8'hFF || frame_tick !== 1'b0) begin
         miss++;
         $display("FAIL async_reset AN=%h SEG=%h ft=%b, want FF FF 0", AN, SEG, frame_tick);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      capture_frame(-1, 0, -1, 0);
      for (int i = 0; i < 128; i++) begin
         vecs++;
         if (an_obs[i] !== f_an(i, 3'd7, 8'hFF) || seg_obs[i] !== f_seg(i, 3'd7, 8'hFF, s) ||
             ft_obs[i] !== (i == 127)) begin
            miss++;
            $display("FAIL post_reset i=%0d AN=%h SEG=%h ft=%b, want AN=%h SEG=%h", i, an_obs[i],
                     seg_obs[i], ft_obs[i], f_an(i, 3'd7, 8'hFF), f_seg(i, 3'd7, 8'hFF, s));
         end
      end
   endtask

   initial begin
      test_reset;
      test_scan;
      test_shadow;
      test_back_to_back;
      test_pwm;
      test_blank;
      test_lzb;
      test_async_reset;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

endmodule
